// File: rtl/alu_exec_unit.sv
// Handshaked ALU execution unit: single-cycle logic/arith ops plus a
// DATA_W-iteration shift-add multiplier, with registered result and flags.
module alu_exec_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [3:0]        ALUCtrl_i,
    input  logic [DATA_W-1:0] src1_i,
    input  logic [DATA_W-1:0] src2_i,
    output logic              valid_o,
    input  logic              ready_i,
    output logic [DATA_W-1:0] result_o,
    output logic              zero_o,
    output logic              err_o
);

    localparam int CNT_W = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(DATA_W - 1);

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_MUL = 4'b1000;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t            state;
    logic [DATA_W-1:0] mcand;
    logic [DATA_W-1:0] mplier;
    logic [DATA_W-1:0] acc;
    logic [CNT_W-1:0]  cnt;

    logic [DATA_W-1:0] alu_res;
    logic              alu_err;
    logic [DATA_W-1:0] acc_next;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (ALUCtrl_i)
            OP_AND:  alu_res = src1_i & src2_i;
            OP_OR:   alu_res = src1_i | src2_i;
            OP_ADD:  alu_res = src1_i + src2_i;
            OP_SUB:  alu_res = src1_i - src2_i;
            OP_SLT:  alu_res = {{(DATA_W-1){1'b0}}, ($signed(src1_i) < $signed(src2_i))};
            default: alu_err = 1'b1;
        endcase
    end

    assign acc_next = acc + (mplier[0] ? mcand : '0);

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state    <= IDLE;
            ready_o  <= 1'b1;
            valid_o  <= 1'b0;
            result_o <= '0;
            zero_o   <= 1'b0;
            err_o    <= 1'b0;
            mcand    <= '0;
            mplier   <= '0;
            acc      <= '0;
            cnt      <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (valid_i && ready_o) begin
                        mcand   <= src1_i;
                        mplier  <= src2_i;
                        acc     <= '0;
                        cnt     <= '0;
                        ready_o <= 1'b0;
                        if (ALUCtrl_i == OP_MUL) begin
                            state <= BUSY;
                        end else begin
                            result_o <= alu_res;
                            zero_o   <= (alu_res == '0);
                            err_o    <= alu_err;
                            valid_o  <= 1'b1;
                            state    <= DONE;
                        end
                    end
                end
                BUSY: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + 1'b1;
                    // The last iteration's sum goes straight to the output register.
                    if (cnt == LAST_ITER) begin
                        result_o <= acc_next;
                        zero_o   <= (acc_next == '0);
                        err_o    <= 1'b0;
                        valid_o  <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    if (ready_i) begin
                        valid_o <= 1'b0;
                        ready_o <= 1'b1;
                        state   <= IDLE;
                    end
                end
                default: begin
                    state   <= IDLE;
                    ready_o <= 1'b1;
                    valid_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_exec_unit.sv
// Directed self-checking bench for alu_exec_unit: reset, all op codes,
// multiply latency, backpressure, operand capture and mid-multiply reset.
module tb_alu_exec_unit;

    logic        clk;
    logic        rst_i;
    logic        valid_i;
    logic        ready_o;
    logic [3:0]  ALUCtrl_i;
    logic [31:0] src1_i;
    logic [31:0] src2_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] result_o;
    logic        zero_o;
    logic        err_o;

    int checks = 0;
    int errors = 0;

    alu_exec_unit #(.DATA_W(32)) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .valid_i   (valid_i),
        .ready_o   (ready_o),
        .ALUCtrl_i (ALUCtrl_i),
        .src1_i    (src1_i),
        .src2_i    (src2_i),
        .valid_o   (valid_o),
        .ready_i   (ready_i),
        .result_o  (result_o),
        .zero_o    (zero_o),
        .err_o     (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Present a request, accept it, then measure cycles until valid_o.
    // With ready_i high the output handshake and return to IDLE are checked too.
    task automatic run_op(input string tag, input logic [3:0] op,
                          input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] res, input logic z, input logic e,
                          input int lat);
        int n;
        @(negedge clk);
        check({tag, " ready_before"}, ready_o, 1'b1);
        ALUCtrl_i = op;
        src1_i    = a;
        src2_i    = b;
        valid_i   = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        n = 1;
        while (!valid_o && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check({tag, " latency"}, n, lat);
        check({tag, " result"}, result_o, res);
        check({tag, " zero"}, zero_o, z);
        check({tag, " err"}, err_o, e);
        if (ready_i) begin
            @(posedge clk);
            #1;
            check({tag, " valid_drop"}, valid_o, 1'b0);
            check({tag, " ready_back"}, ready_o, 1'b1);
            check({tag, " result_held"}, result_o, res);
        end
    endtask

    initial begin
        bit seen_valid;
        rst_i     = 1'b0;
        valid_i   = 1'b0;
        ready_i   = 1'b1;
        ALUCtrl_i = 4'b0000;
        src1_i    = '0;
        src2_i    = '0;

        #12;
        check("rst ready", ready_o, 1'b1);
        check("rst valid", valid_o, 1'b0);
        check("rst result", result_o, 32'h0);
        check("rst zero", zero_o, 1'b0);
        check("rst err", err_o, 1'b0);
        @(negedge clk);
        rst_i = 1'b1;

        run_op("add_wrap", 4'b0010, 32'hFFFF_FFFF, 32'h1, 32'h0, 1'b1, 1'b0, 1);
        run_op("sub", 4'b0110, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1);
        run_op("and", 4'b0000, 32'hF0F0, 32'hFF00, 32'hF000, 1'b0, 1'b0, 1);
        run_op("or", 4'b0001, 32'h1, 32'h2, 32'h3, 1'b0, 1'b0, 1);
        run_op("slt_neg", 4'b0111, 32'hFFFF_FFFF, 32'h1, 32'h1, 1'b0, 1'b0, 1);
        run_op("slt_pos", 4'b0111, 32'h1, 32'hFFFF_FFFF, 32'h0, 1'b1, 1'b0, 1);

        run_op("mul_zero", 4'b1000, 32'h0001_0000, 32'h0001_0000, 32'h0, 1'b1, 1'b0, 33);
        run_op("mul_neg", 4'b1000, 32'hFFFF_FFFF, 32'd3, 32'hFFFF_FFFD, 1'b0, 1'b0, 33);
        run_op("mul_dec", 4'b1000, 32'd123, 32'd456, 32'd56088, 1'b0, 1'b0, 33);

        // Backpressure: result must stay put while operands wander.
        ready_i = 1'b0;
        run_op("bp_add", 4'b0010, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, 1);
        src1_i = 32'hDEAD_BEEF;
        src2_i = 32'h1234_5678;
        valid_i = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            check("bp valid", valid_o, 1'b1);
            check("bp result", result_o, 32'd5);
            check("bp ready", ready_o, 1'b0);
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("bp release valid", valid_o, 1'b0);
        check("bp release ready", ready_o, 1'b1);
        check("bp release result", result_o, 32'd5);

        run_op("unsupported", 4'b1111, 32'd3, 32'd4, 32'h0, 1'b1, 1'b1, 1);
        run_op("err_clear", 4'b0010, 32'd2, 32'd2, 32'd4, 1'b0, 1'b0, 1);

        // Reset in the middle of a multiply discards it.
        @(negedge clk);
        ALUCtrl_i = 4'b1000;
        src1_i    = 32'd7;
        src2_i    = 32'd9;
        valid_i   = 1'b1;
        @(posedge clk);
        #1;
        valid_i = 1'b0;
        repeat (10) @(posedge clk);
        #2;
        rst_i = 1'b0;
        #1;
        check("midrst ready", ready_o, 1'b1);
        check("midrst valid", valid_o, 1'b0);
        check("midrst result", result_o, 32'h0);
        check("midrst err", err_o, 1'b0);
        @(posedge clk);
        @(negedge clk);
        rst_i = 1'b1;
        seen_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk);
            #1;
            if (valid_o) seen_valid = 1'b1;
        end
        check("midrst no_valid", seen_valid, 1'b0);
        run_op("post_rst_add", 4'b0010, 32'd1, 32'd1, 32'd2, 1'b0, 1'b0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/alu_exec_unit.md
# alu_exec_unit

- Handshaked execution unit on the consuming side of the ALU control interface.
- Accepts a 4-bit ALU control code with two 32-bit operands and produces a registered result, a zero flag and an error flag.
- Logic ops complete in one cycle; multiply is a 32-iteration shift-add sequence.
- Sits between the ALU controller/operand fetch and writeback in the multi-cycle datapath.

## Interface
- DATA_W, 32, operand/result width; the multiply iteration count equals DATA_W.
- clk_i  input  1  clock, all state updates on the rising edge.
- rst_i  input  1  reset, asynchronous, active-low.
- valid_i  input  1  request valid.
- ready_o  output  1  unit can accept a request.
- ALUCtrl_i  input  4  operation code.
- src1_i  input  DATA_W  operand A.
- src2_i  input  DATA_W  operand B.
- valid_o  output  1  result valid.
- ready_i  input  1  downstream accepts the result.
- result_o  output  DATA_W  operation result.
- zero_o  output  1  high when result_o == 0.
- err_o  output  1  high when the op code is unsupported.

## Operation
- Op codes:
  - 4'b0000 AND.
  - 4'b0001 OR.
  - 4'b0010 ADD, wrap-around modulo 2^DATA_W, no overflow flag.
  - 4'b0110 SUB (A−B), wrap-around modulo 2^DATA_W.
  - 4'b0111 SLT, signed two's-complement; result is 1 or 0.
  - 4'b1000 MUL, low DATA_W bits of A×B; identical for signed and unsigned.
  - Any other code: result 0, err_o=1, zero_o=1.
- FSM states IDLE, BUSY, DONE.
- IDLE:
  - ready_o=1.
  - On valid_i&&ready_o, latch ALUCtrl_i, src1_i and src2_i.
  - MUL → BUSY, with accumulator cleared and iteration counter = 0.
  - All other codes → DONE, with the result computed and registered on the accept edge.
- BUSY:
  - Each cycle, if multiplier bit 0 is set, accumulator += multiplicand.
  - Then multiplicand <<= 1, multiplier >>= 1, counter += 1.
  - After the DATA_W-th iteration, register the result → DONE.
  - Counter width is ceil(log2(DATA_W))+1 and must not wrap.
- DONE:
  - valid_o=1; result_o, zero_o and err_o are held stable.
  - On valid_o&&ready_i → IDLE.
- ready_o is 0 in BUSY and DONE, so inputs there are ignored.
- valid_i while ready_o=0 is not an error; the requester must hold it until accepted.
- Operands are captured at accept; later input changes do not affect the result.
- zero_o and err_o are registered alongside result_o.

## Timing
- Reset (rst_i low, any time, including mid-multiply):
  - State → IDLE; ready_o=1; valid_o=0; result_o=0; zero_o=0; err_o=0.
  - Accumulator and counter are cleared; any in-flight op is discarded with no output.
- Deassertion of rst_i is synchronised by the user. The first accept is possible on the first edge after release.
- Latency from accept edge to valid_o high:
  - Single-cycle ops: 1 cycle (valid_o is high in the cycle after accept).
  - MUL: DATA_W+1 cycles (33 for the default).
  - Unsupported codes: 1 cycle.
- Throughput:
  - One op per 2 cycles for single-cycle ops when ready_i is tied high (accept, DONE, back to IDLE).
  - MUL with ready_i tied high: one op per DATA_W+2 cycles.
- Backpressure: with ready_i low, DONE holds indefinitely with outputs unchanged.
- Outputs after return to IDLE:
  - valid_o drops the cycle after the output handshake.
  - result_o, zero_o and err_o keep their last values until the next completion.
- valid_i and ready_i may both be high in DONE. Only the output handshake fires; no new accept occurs until IDLE.

## Test plan
- Reset value and reset clearing:
  - Reset → ready_o=1, valid_o=0, result_o=0, zero_o=0, err_o=0.
  - Assert rst_i low at BUSY iteration 10 of MUL 7×9 → immediate IDLE, valid_o never asserts, next ADD 1+1 returns 2.
- Single-cycle ops with ready_i=1:
  - ADD 0xFFFFFFFF+1 → result 0, zero_o=1, valid_o one cycle after accept.
  - SUB 5−7 → 0xFFFFFFFE.
  - AND 0xF0F0&0xFF00 → 0xF000.
  - OR 0x1|0x2 → 0x3.
- SLT is signed:
  - A=0xFFFFFFFF (−1), B=1 → 1.
  - A=1, B=0xFFFFFFFF → 0, zero_o=1.
- MUL:
  - 0x0001_0000×0x0001_0000 → 0, zero_o=1, valid_o exactly 33 cycles after accept.
  - 0xFFFFFFFF×3 → 0xFFFFFFFD.
  - 123×456 → 56088.
- Backpressure and input capture:
  - Hold ready_i=0 for 10 cycles after completion of ADD 2+3 → valid_o stays 1, result_o stays 5, ready_o stays 0.
  - Changing src1_i/src2_i during the wait does not alter result_o.
  - Raise ready_i → valid_o falls the next cycle and ready_o rises.
- Unsupported code 4'b1111 with operands 3,4 → result 0, err_o=1, zero_o=1 after 1 cycle; the next valid ADD clears err_o.
